// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] ADDR_TXDATA = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ACK_ERR = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_OVERRUN = 4;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a clock falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle bus is high; resetting to 1 avoids a phantom falling edge after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with a small memory-mapped register interface.
// state     | meaning
// IDLE      | lines released, accepting a TX byte
// INHIBIT   | clock held low, then request-to-send
// START     | start bit on the line, waiting for falling edge 1
// SHIFT     | data bits 1-7 and parity on edges 2-9
// STOP      | release data for the stop bit on edge 10
// ACK       | sample device acknowledge on edge 11
// WAIT_IDLE | wait for both lines high before finishing
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [7:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e       state, state_nxt;
    logic [7:0]       tx_byte, byte_nxt;
    logic [3:0]       bit_idx, idx_nxt;
    logic             data_drive, drive_nxt;
    logic [INH_W-1:0] inh_cnt, inh_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic             ack_ok, ack_ok_nxt;
    logic             set_ack_err, set_timeout, frame_ok;
    logic             done_flag, ack_err_flag, timeout_flag, overrun_flag;
    logic             clk_sync, data_sync, clk_fall;
    logic             wr_tx, rd_status;
    logic [31:0]      status_vec;
    logic             unused_wdata;

    ps2_line_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    assign unused_wdata = ^mem_wdata[31:8];
    assign wr_tx        = mem_write && (mem_addr == ADDR_TXDATA);
    assign rd_status    = mem_read && (mem_addr == ADDR_STATUS);
    assign tx_busy      = (state != IDLE);
    assign ps2_clk_oe   = (state == INHIBIT);
    assign ps2_data_oe  = data_drive;

    always_comb begin
        state_nxt   = state;
        byte_nxt    = tx_byte;
        idx_nxt     = bit_idx;
        drive_nxt   = data_drive;
        inh_nxt     = inh_cnt;
        to_nxt      = to_cnt;
        ack_ok_nxt  = ack_ok;
        set_ack_err = 1'b0;
        set_timeout = 1'b0;
        frame_ok    = 1'b0;
        if (state inside {START, SHIFT, STOP, ACK, WAIT_IDLE}) begin
            to_nxt = to_cnt - TO_W'(1);
        end
        // Timeout has priority over any line event seen in the same cycle.
        if (state inside {START, SHIFT, STOP, ACK, WAIT_IDLE} && to_cnt == '0) begin
            state_nxt   = IDLE;
            drive_nxt   = 1'b0;
            set_timeout = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_tx) begin
                        byte_nxt  = mem_wdata[7:0];
                        inh_nxt   = INH_W'(INHIBIT_CYCLES - 1);
                        state_nxt = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == '0) begin
                        drive_nxt = 1'b1;
                        to_nxt    = TO_W'(TIMEOUT_CYCLES - 1);
                        state_nxt = START;
                    end else begin
                        inh_nxt = inh_cnt - INH_W'(1);
                    end
                end
                START: begin
                    if (clk_fall) begin
                        drive_nxt = ~tx_byte[0];
                        idx_nxt   = 4'd1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_fall) begin
                        if (bit_idx == 4'd8) begin
                            drive_nxt = ~odd_parity(tx_byte);
                            state_nxt = STOP;
                        end else begin
                            drive_nxt = ~tx_byte[bit_idx[2:0]];
                            idx_nxt   = bit_idx + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        drive_nxt = 1'b0;
                        state_nxt = ACK;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        ack_ok_nxt  = ~data_sync;
                        set_ack_err = data_sync;
                        state_nxt   = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        frame_ok  = ack_ok;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        status_vec               = '0;
        status_vec[STAT_BUSY]    = tx_busy;
        status_vec[STAT_DONE]    = done_flag;
        status_vec[STAT_ACK_ERR] = ack_err_flag;
        status_vec[STAT_TIMEOUT] = timeout_flag;
        status_vec[STAT_OVERRUN] = overrun_flag;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            tx_byte      <= '0;
            bit_idx      <= '0;
            data_drive   <= 1'b0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            ack_ok       <= 1'b0;
            done_flag    <= 1'b0;
            ack_err_flag <= 1'b0;
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
            mem_rdata    <= '0;
            tx_done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            tx_byte      <= byte_nxt;
            bit_idx      <= idx_nxt;
            data_drive   <= drive_nxt;
            inh_cnt      <= inh_nxt;
            to_cnt       <= to_nxt;
            ack_ok       <= ack_ok_nxt;
            tx_done      <= frame_ok;
            // Sticky flags: a set in the same cycle as a status read survives the clear.
            done_flag    <= frame_ok    | (done_flag    & ~rd_status);
            ack_err_flag <= set_ack_err | (ack_err_flag & ~rd_status);
            timeout_flag <= set_timeout | (timeout_flag & ~rd_status);
            overrun_flag <= (wr_tx && state != IDLE) | (overrun_flag & ~rd_status);
            if (mem_read) begin
                mem_rdata <= rd_status ? status_vec : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a frame/status model checks them.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_oe, ps2_data_oe;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [7:0]  mem_addr = 8'h00;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        tx_busy, tx_done;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;
    int inh_run = 0;
    int last_inh = 0;
    bit m_done, m_ackerr, m_timeout, m_overrun;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    // Open-drain bus: a line is high only if neither side pulls it low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as the device sees it: index 0 start, 1-8 data LSB-first, 9 odd parity, 10 stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    function automatic logic [31:0] status_model(input bit ov, input bit tmo, input bit ae, input bit dn);
        return {27'd0, ov, tmo, ae, dn, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_done) done_cnt++;
            if (ps2_clk_oe) begin
                inh_run++;
            end else if (inh_run != 0) begin
                last_inh = inh_run;
                inh_run  = 0;
            end
            if (ps2_clk_oe || ps2_data_oe)
                check("oe_busy_excl", {30'd0, tx_busy, ps2_clk_oe & ps2_data_oe}, 32'd2);
        end
    end

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1; mem_addr = a; mem_wdata = d;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] r);
        @(negedge clk);
        mem_read = 1'b1; mem_addr = a;
        @(negedge clk);
        mem_read = 1'b0;
        r = mem_rdata;
    endtask

    task automatic wait_clk_oe(input logic val, input int limit, input string name);
        int n = 0;
        while (ps2_clk_oe !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, ps2_clk_oe}, {31'd0, val});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_clears", {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic read_status_checked(input string name);
        logic [31:0] r;
        cpu_read(8'h01, r);
        check(name, r, status_model(m_overrun, m_timeout, m_ackerr, m_done));
        m_overrun = 0; m_timeout = 0; m_ackerr = 0; m_done = 0;
    endtask

    task automatic run_frame(input int half, input bit ack, output logic [10:0] bits);
        wait_clk_oe(1'b1, 20, "rts_inhibit");
        wait_clk_oe(1'b0, INH + 20, "rts_release");
        repeat ($urandom_range(2, 20)) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            if (i <= 10) bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (half) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input int half, input bit ack, output logic [10:0] bits);
        int d0;
        d0 = done_cnt;
        cpu_write(8'h00, {24'd0, b});
        run_frame(half, ack, bits);
        wait_idle(60);
        repeat (3) @(negedge clk);
        if (ack) m_done = 1; else m_ackerr = 1;
        check("frame_bits", {21'd0, bits}, {21'd0, frame_model(b)});
        check("tx_done_pulses", done_cnt - d0, {31'd0, ack});
        check("inhibit_len", last_inh, INH);
    endtask

    initial begin
        logic [10:0] bits;
        logic [31:0] r;
        logic [7:0]  b;
        int          n;

        repeat (4) @(negedge clk);
        check("reset_outputs", {28'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with ACK: literal frame and status expectations.
        do_frame(8'hED, 8, 1'b1, bits);
        check("ed_bits_literal", {21'd0, bits}, 32'h7DA);
        cpu_read(8'h01, r);
        check("ed_status", r, 32'h02);
        cpu_read(8'h01, r);
        check("ed_status_cleared", r, 32'h00);
        m_done = 0;

        do_frame(8'h00, 6, 1'b1, bits);
        check("zero_bits_literal", {21'd0, bits}, 32'h600);
        read_status_checked("zero_status");

        // Device leaves data high at edge 11.
        do_frame(8'h5A, 7, 1'b0, bits);
        cpu_read(8'h01, r);
        check("nack_status", r, 32'h04);
        cpu_read(8'h01, r);
        check("nack_status_cleared", r, 32'h00);
        m_ackerr = 0;

        // Device never clocks.
        cpu_write(8'h00, 32'h0000_00A5);
        wait_clk_oe(1'b1, 20, "tmo_inhibit");
        wait_clk_oe(1'b0, INH + 20, "tmo_release");
        check("tmo_start_bit", {31'd0, ps2_data_oe}, 32'd1);
        n = 0;
        while (ps2_data_oe && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_window", {31'd0, (n >= 490 && n <= 501)}, 32'd1);
        check("tmo_idle", {30'd0, tx_busy, ps2_data_oe}, 32'd0);
        m_timeout = 1;
        cpu_read(8'h01, r);
        check("tmo_status", r, 32'h08);
        m_timeout = 0;

        // Overrun: second write during inhibit must not change the byte in flight.
        cpu_write(8'h00, 32'h0000_00F4);
        repeat (5) @(negedge clk);
        cpu_write(8'h00, 32'h0000_00FF);
        m_overrun = 1;
        run_frame(9, 1'b1, bits);
        wait_idle(60);
        m_done = 1;
        check("overrun_bits", {21'd0, bits}, {21'd0, frame_model(8'hF4)});
        cpu_read(8'h01, r);
        check("overrun_status", r, 32'h12);
        m_done = 0; m_overrun = 0;

        cpu_write(8'h07, 32'h0000_0033);
        @(negedge clk);
        check("other_addr_write", {31'd0, tx_busy}, 32'd0);
        cpu_read(8'h05, r);
        check("other_addr_read", r, 32'd0);

        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            do_frame(b, $urandom_range(5, 10), ($urandom_range(0, 4) != 0), bits);
            read_status_checked("rand_status");
        end

        // Reset while bit 4 is on the line (bit 4 forced to 0 so data is pulled low).
        b = 8'($urandom) & 8'hEF;
        cpu_write(8'h00, {24'd0, b});
        wait_clk_oe(1'b1, 20, "rst_inhibit");
        wait_clk_oe(1'b0, INH + 20, "rst_release");
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            if (i < 5) begin
                dev_clk = 1'b1;
                repeat (8) @(negedge clk);
            end
        end
        check("bit4_driven", {31'd0, ps2_data_oe}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_midframe", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        cpu_read(8'h01, r);
        check("post_reset_status", r, 32'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
